rc_unicast_nport: RTL
=====================

# rc_unicast_nport

Parametrised routing-computation stage for the mesh router, the successor to the fixed five-port unicast RC block. Each of NPORTS input channels gets its own DEPTH-entry flit FIFO. The route is computed when a flit is enqueued, using dimension-ordered routing (XY or YX, chosen by parameter) on a MESH_X × MESH_Y mesh. Each output carries a valid/ready handshake toward switch allocation, and a sticky per-port error flag records destinations outside the mesh.

## Interface
- NPORTS, 5: number of input channels; index 0=N, 1=E, 2=W, 3=S, 4=L when 5.
- DEPTH, 4: FIFO entries per port, power of two, ≥2.
- WIDTH, 2: log2(DEPTH), pointer width.
- DATASIZE, 30: flit width.
- MESH_X, 4: mesh columns.
- MESH_Y, 4: mesh rows.
- ID_W, 4: destination-ID field width, ≥ clog2(MESH_X*MESH_Y).
- router_ID, 6: this router's node ID; x = router_ID % MESH_X, y = router_ID / MESH_X.
- ROUTE_MODE, 0: 0 = XY (X first), 1 = YX (Y first).
- rc_clk  in  1  single clock; all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  NPORTS*DATASIZE  flits, port p at [p*DATASIZE +: DATASIZE].
- valid_in  in  NPORTS  per-port flit valid.
- in_ready  out  NPORTS  per-port FIFO not full.
- data_out  out  NPORTS*DATASIZE  head flit per port.
- direction_out  out  NPORTS*5  one-hot route of head flit: bit0 N, bit1 E, bit2 W, bit3 S, bit4 L.
- valid_out  out  NPORTS  per-port FIFO not empty.
- rc_ready  in  NPORTS  downstream accepts head flit.
- route_err  out  NPORTS  sticky: port has received a flit with an invalid destination.

## Operation
- Destination field: dest = flit[DATASIZE-1 -: ID_W]; dx = dest % MESH_X, dy = dest / MESH_X.
- Route, XY mode:
  - dx > x → E; dx < x → W;
  - otherwise dy < y → N; dy > y → S;
  - otherwise L.
- Route, YX mode: Y comparison first, then X, then L. N is decreasing y.
- Invalid destination (dest ≥ MESH_X*MESH_Y):
  - flit is still enqueued, with direction 5'b00000;
  - route_err[p] is set on the enqueue cycle and held until rst;
  - downstream drains the flit normally.
- Per port FIFO:
  - storage holds DATASIZE + 5 bits per entry; the direction is stored alongside the flit.
  - write pointer, read pointer, and a count of WIDTH+1 bits.
- Push when valid_in[p] && in_ready[p]. Valid flits presented while in_ready[p] is low are dropped, not stalled; upstream must honour in_ready.
- Pop when valid_out[p] && rc_ready[p]. rc_ready with an empty FIFO has no effect.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Full FIFO:
  - in_ready = 0, even if a pop happens that cycle (no bypass);
  - in_ready returns to 1 the cycle after the pop.
- data_out and direction_out are the storage entry at the read pointer. They are undefined-but-stable while valid_out = 0, and hold their value while valid_out = 1 and rc_ready = 0.
- Ports are fully independent; there is no cross-port arbitration.

## Timing
- Reset, asynchronous and immediate:
  - count = 0 and both pointers = 0;
  - valid_out = 0, in_ready = all ones, route_err = 0;
  - direction_out = 0, data_out = 0 (storage is cleared).
- Reset mid-operation discards all queued flits; nothing is delivered after rst deasserts.
- Latency: a flit pushed at edge t is visible with valid_out = 1 after edge t (combinationally from registers), i.e. one cycle of enqueue-to-head latency.
- Throughput: one flit per cycle per port when rc_ready is held high.
- in_ready and valid_out are functions of registered count only; there is no combinational path from valid_in or rc_ready.
- route_err rises in the cycle after the offending push edge.

## Test plan
- Route decode, router_ID = 6 (x2, y1), 4×4 mesh, XY:
  - dest 7 → 5'b00010 (E)
  - dest 2 → 5'b00001 (N)
  - dest 6 → 5'b10000 (L)
  - dest 13 → 5'b00100 (W)
  - Rerun with ROUTE_MODE = 1: dest 13 → 5'b01000 (S).
- Full/backpressure on port 0, rc_ready = 0:
  - push flits A, B, C, D → in_ready[0] = 0 after the fourth edge;
  - a fifth flit E is dropped;
  - raise rc_ready → A, B, C, D emerge in order, one per cycle, then valid_out = 0.
- Full with simultaneous pop: with 4 queued, assert valid_in and rc_ready together → new flit not accepted, count = 3, in_ready = 1 next cycle.
- Streaming with wrap: 20 consecutive flits on port 4 with rc_ready high → all delivered in order, one per cycle after 1-cycle latency; pointers wrap without loss.
- Invalid destination: MESH_X = MESH_Y = 3, ID_W = 4, dest 12 on port 2 → direction_out = 5'b00000 with valid_out = 1, route_err[2] = 1 and stays 1; other ports' route_err stay 0.
- Reset mid-stream: 3 flits queued on all ports, assert rst asynchronously between edges → valid_out = 0, in_ready = all ones, and route_err = 0 immediately; no flits appear after release.

Source files
------------

// File: rtl/rc_unicast_nport.sv
// rc_unicast_nport: per-port flit FIFOs; the dimension-ordered route (XY or YX) is computed at enqueue and stored with the flit.
// Ports: rc_clk/rst (async active-high); data_in/valid_in/in_ready upstream; data_out/direction_out/valid_out/rc_ready downstream; route_err sticky per port.
// Latency: one cycle enqueue-to-head. Backpressure: in_ready low when full (no bypass); flits offered while in_ready is low are dropped.
module rc_unicast_nport #(
    parameter int NPORTS     = 5,
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 2,
    parameter int DATASIZE   = 30,
    parameter int MESH_X     = 4,
    parameter int MESH_Y     = 4,
    parameter int ID_W       = 4,
    parameter int router_ID  = 6,
    parameter int ROUTE_MODE = 0
) (
    input  logic                         rc_clk,
    input  logic                         rst,
    input  logic [NPORTS*DATASIZE-1:0]   data_in,
    input  logic [NPORTS-1:0]            valid_in,
    output logic [NPORTS-1:0]            in_ready,
    output logic [NPORTS*DATASIZE-1:0]   data_out,
    output logic [NPORTS*5-1:0]          direction_out,
    output logic [NPORTS-1:0]            valid_out,
    input  logic [NPORTS-1:0]            rc_ready,
    output logic [NPORTS-1:0]            route_err
);
    localparam int NODES = MESH_X * MESH_Y;
    localparam int X0    = router_ID % MESH_X;
    localparam int Y0    = router_ID / MESH_X;
    localparam int EW    = DATASIZE + 5;
    localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);

    // Direction encoding: bit0 N, bit1 E, bit2 W, bit3 S, bit4 L
    localparam logic [4:0] DIR_N = 5'b00001;
    localparam logic [4:0] DIR_E = 5'b00010;
    localparam logic [4:0] DIR_W = 5'b00100;
    localparam logic [4:0] DIR_S = 5'b01000;
    localparam logic [4:0] DIR_L = 5'b10000;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [DATASIZE-1:0] flit_in;
        logic [ID_W-1:0]     dest;
        int                  dest_i;
        int                  dx;
        int                  dy;
        logic [4:0]          dir;
        logic                bad;
        logic [EW-1:0]       mem_q [DEPTH];
        logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
        logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
        logic [WIDTH:0]      count_q, count_d;
        logic                err_q, err_d;
        logic                push, pop;

        assign flit_in = data_in[p*DATASIZE +: DATASIZE];
        assign dest    = flit_in[DATASIZE-1 -: ID_W];

        // Route of the incoming flit; out-of-mesh destinations get no direction
        always_comb begin
            dest_i = int'(dest);
            dx     = dest_i % MESH_X;
            dy     = dest_i / MESH_X;
            dir    = 5'b00000;
            bad    = 1'b0;
            if (dest_i >= NODES) begin
                bad = 1'b1;
            end else if (ROUTE_MODE == 0) begin
                if (dx > X0)      dir = DIR_E;
                else if (dx < X0) dir = DIR_W;
                else if (dy < Y0) dir = DIR_N;
                else if (dy > Y0) dir = DIR_S;
                else              dir = DIR_L;
            end else begin
                if (dy < Y0)      dir = DIR_N;
                else if (dy > Y0) dir = DIR_S;
                else if (dx > X0) dir = DIR_E;
                else if (dx < X0) dir = DIR_W;
                else              dir = DIR_L;
            end
        end

        // Handshakes depend only on the registered count
        assign in_ready[p]  = (count_q != FULL_CNT);
        assign valid_out[p] = (count_q != '0);
        assign push         = valid_in[p] & in_ready[p];
        assign pop          = valid_out[p] & rc_ready[p];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            err_d    = err_q | (push & bad);
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end

        always_ff @(posedge rc_clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                err_q    <= 1'b0;
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                err_q    <= err_d;
                if (push) mem_q[wr_ptr_q] <= {dir, flit_in};
            end
        end

        assign data_out[p*DATASIZE +: DATASIZE] = mem_q[rd_ptr_q][DATASIZE-1:0];
        assign direction_out[p*5 +: 5]          = mem_q[rd_ptr_q][EW-1 -: 5];
        assign route_err[p]                     = err_q;
    end
endmodule
